// File: rtl/merge_pkg.sv
// -----------------------------------------------------------------------------
// merge_pkg
// Shared types and constants for the merge line-buffer sequencer.
//   merge_state_t : sequencer states (IDLE, FILL, WAIT_SWAP)
//   COORD_W       : default width of pixel coordinates
//   SEG_PIXELS    : default pixels per buffer fill (128-bit buffer / 8-bit channel)
//   PIXEL_W       : bits per colour channel
//   COLL_W        : number of collision flag bits produced by the merge stage
// -----------------------------------------------------------------------------
package merge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2
    } merge_state_t;

    localparam int COORD_W    = 10;
    localparam int SEG_PIXELS = 16;
    localparam int PIXEL_W    = 8;
    localparam int COLL_W     = 4;

endpackage

// File: rtl/merge_pos_counter.sv
// -----------------------------------------------------------------------------
// merge_pos_counter
// Raster X/Y counter for the merge sequencer. Advances one pixel per accepted
// pixel, wraps X at the end of a line and both X and Y at the end of a frame.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   advance      : step to the next pixel on this edge
//   pos_x, pos_y : current pixel column / line
//   frame_end    : one-cycle pulse in the cycle after the last pixel was taken
// -----------------------------------------------------------------------------
module merge_pos_counter
    import merge_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               frame_end
);

    logic [COORD_W-1:0] pos_x_reg;
    logic [COORD_W-1:0] pos_y_reg;
    logic               frame_end_reg;
    logic               last_x;
    logic               last_y;

    assign last_x = (pos_x_reg == COORD_W'(H_ACTIVE - 1));
    assign last_y = (pos_y_reg == COORD_W'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x_reg     <= '0;
            pos_y_reg     <= '0;
            frame_end_reg <= 1'b0;
        end else begin
            frame_end_reg <= advance && last_x && last_y;
            if (advance) begin
                if (last_x) begin
                    pos_x_reg <= '0;
                    pos_y_reg <= last_y ? '0 : pos_y_reg + COORD_W'(1);
                end else begin
                    pos_x_reg <= pos_x_reg + COORD_W'(1);
                end
            end
        end
    end

    assign pos_x     = pos_x_reg;
    assign pos_y     = pos_y_reg;
    assign frame_end = frame_end_reg;

endmodule

// File: rtl/merge_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// merge_buffer_ctrl
// Sequencer for the merge ping-pong line buffers. Requests pixels from the
// background/sprite fetchers, pulses merge writes into the fill buffer and
// swaps the VGA read buffer once a segment is full and VGA has drained the
// other buffer.
// Optional feature macro: MERGE_CTRL_COLLISION_LATCH_EN (sticky collision flags).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : run request, sampled in IDLE and at segment boundaries
//   pix_req/pix_valid : fetch handshake for pixel (posX, posY)
//   posX, posY        : current pixel coordinates
//   merge_we          : write the merged pixel into the fill buffer (comb.)
//   readVgaSelector   : 1 = VGA reads B / merge fills A, 0 = the reverse
//   vga_consumed      : pulse, VGA finished with its read buffer
//   buf_ready         : read buffer holds a complete segment
//   frame_done        : pulse after the last pixel of the frame was taken
//   collision, coll_clear, collision_flags : sticky collision reporting
// -----------------------------------------------------------------------------
module merge_buffer_ctrl
    import merge_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SEG_PIXELS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               pix_req,
    input  logic               pix_valid,
    output logic [COORD_W-1:0] posX,
    output logic [COORD_W-1:0] posY,
    output logic               merge_we,
    output logic               readVgaSelector,
    input  logic               vga_consumed,
    output logic               buf_ready,
    output logic               frame_done,
    input  logic [COLL_W-1:0]  collision,
    input  logic               coll_clear,
    output logic [COLL_W-1:0]  collision_flags
);

    localparam int SEG_CNT_W = (SEG_PIXELS > 1) ? $clog2(SEG_PIXELS) : 1;

    // Segments must tile a line exactly so a segment never straddles two lines.
    if ((H_ACTIVE % SEG_PIXELS) != 0) begin : g_bad_h_active
        $error("H_ACTIVE must be a multiple of SEG_PIXELS");
    end

    merge_state_t         state_reg;
    logic                 pix_req_reg;
    logic                 sel_reg;
    logic                 buf_ready_reg;
    logic [SEG_CNT_W-1:0] seg_cnt_reg;
    logic                 consumed_pend_reg;
    logic                 first_fill_reg;

    logic accept;
    logic seg_last;
    logic swap_ok;

    assign accept   = pix_req_reg & pix_valid;
    assign merge_we = accept;
    assign seg_last = (seg_cnt_reg == SEG_CNT_W'(SEG_PIXELS - 1));
    // The very first segment has no reader yet, so it may swap unconditionally.
    assign swap_ok  = first_fill_reg | consumed_pend_reg | vga_consumed;

    merge_pos_counter #(
        .COORD_W  (COORD_W),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .clk       (clk),
        .reset     (reset),
        .advance   (accept),
        .pos_x     (posX),
        .pos_y     (posY),
        .frame_end (frame_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            pix_req_reg       <= 1'b0;
            sel_reg           <= 1'b1;
            buf_ready_reg     <= 1'b0;
            seg_cnt_reg       <= '0;
            consumed_pend_reg <= 1'b0;
            first_fill_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (vga_consumed) consumed_pend_reg <= 1'b1;
                    if (enable) begin
                        state_reg   <= FILL;
                        pix_req_reg <= 1'b1;
                    end
                end
                FILL: begin
                    // Remember one early consume; overridden below if this edge swaps.
                    if (vga_consumed) consumed_pend_reg <= 1'b1;
                    if (accept) begin
                        if (seg_last) begin
                            seg_cnt_reg <= '0;
                            if (swap_ok) begin
                                sel_reg           <= ~sel_reg;
                                buf_ready_reg     <= 1'b1;
                                first_fill_reg    <= 1'b0;
                                consumed_pend_reg <= 1'b0;
                                state_reg         <= enable ? FILL : IDLE;
                                pix_req_reg       <= enable;
                            end else begin
                                state_reg   <= WAIT_SWAP;
                                pix_req_reg <= 1'b0;
                            end
                        end else begin
                            seg_cnt_reg <= seg_cnt_reg + SEG_CNT_W'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (vga_consumed) begin
                        sel_reg           <= ~sel_reg;
                        consumed_pend_reg <= 1'b0;
                        state_reg         <= enable ? FILL : IDLE;
                        pix_req_reg       <= enable;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    pix_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pix_req         = pix_req_reg;
    assign readVgaSelector = sel_reg;
    assign buf_ready       = buf_ready_reg;

`ifdef MERGE_CTRL_COLLISION_LATCH_EN
    logic [COLL_W-1:0] coll_flags_reg;

    // Per-bit sticky flag: a new collision on a write beats a same-cycle clear.
    for (genvar gi = 0; gi < COLL_W; gi++) begin : g_coll
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                coll_flags_reg[gi] <= 1'b0;
            end else if (merge_we && collision[gi]) begin
                coll_flags_reg[gi] <= 1'b1;
            end else if (coll_clear) begin
                coll_flags_reg[gi] <= 1'b0;
            end
        end
    end

    assign collision_flags = coll_flags_reg;
`else
    logic unused_coll;
    assign unused_coll     = ^{collision, coll_clear};
    assign collision_flags = '0;
`endif

endmodule
